// File: rtl/icache_pkg.sv
// Shared geometry and state encoding for the direct-mapped instruction cache.
// The 16-bit byte address splits as tag[15:11] | index[10:3] | word[2:1] | 0.
package icache_pkg;
  localparam int SETS     = 256;
  localparam int LINE_WDS = 4;
  localparam int MEM_LAT  = 2;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;

  localparam int IDX_W = $clog2(SETS);
  localparam int OFS_W = $clog2(LINE_WDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFS_W - 1;

  localparam int OFS_LSB = 1;
  localparam int IDX_LSB = OFS_LSB + OFS_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_e;
endpackage

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays for the instruction cache: combinational read,
// one word write port plus a tag/valid set for the same line.
module icache_line_store
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFS_W-1:0]  rd_word,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFS_W-1:0]  wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              set_valid,
  input  logic [TAG_W-1:0]  set_tag
);
  logic [DATA_W-1:0] data_q [SETS][LINE_WDS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   valid_d;

  assign rd_data  = data_q[rd_idx][rd_word];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    if (set_valid) valid_d[wr_idx] = 1'b1;
  end

  // Only the valid bits are reset; stale tags/data are harmless once invalid.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en)     data_q[wr_idx][wr_word] <= wr_data;
    if (set_valid) tag_q[wr_idx] <= set_tag;
  end
endmodule

// File: rtl/icache_responder.sv
// Read-only direct-mapped instruction cache: same-cycle hits, in-order line refill
// from a fixed-latency backing memory on a miss, then a one-cycle response.
module icache_responder
  import icache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
);
  localparam logic [OFS_W-1:0] LAST_WD = OFS_W'(LINE_WDS - 1);

  state_e            state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [OFS_W-1:0]  word_q, word_d;
  logic [OFS_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [OFS_W-1:0]  ret_cnt_q, ret_cnt_d;
  logic              issue_done_q, issue_done_d;

  logic [IDX_W-1:0]  rd_idx;
  logic [OFS_W-1:0]  rd_word;
  logic [DATA_W-1:0] rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              wr_en;
  logic              set_valid;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFS_W-1:0]  req_word;

  logic unused_inputs;
  assign unused_inputs = ^{DataIn, createdump};

  assign req_tag  = Addr[TAG_LSB +: TAG_W];
  assign req_idx  = Addr[IDX_LSB +: IDX_W];
  assign req_word = Addr[OFS_LSB +: OFS_W];

  icache_line_store u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (rd_idx),
    .rd_word   (rd_word),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_en     (wr_en),
    .wr_idx    (idx_q),
    .wr_word   (ret_cnt_q),
    .wr_data   (mem_rdata),
    .set_valid (set_valid),
    .set_tag   (tag_q)
  );

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    word_d       = word_q;
    issue_cnt_d  = issue_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    issue_done_d = issue_done_q;
    rd_idx       = req_idx;
    rd_word      = req_word;
    wr_en        = 1'b0;
    set_valid    = 1'b0;
    DataOut      = '0;
    Done         = 1'b0;
    Stall        = 1'b0;
    CacheHit     = 1'b0;
    err          = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = '0;

    case (state_q)
      IDLE: begin
        if (Wr || (Rd && Addr[0])) begin
          err = 1'b1;
        end else if (Rd) begin
          if (rd_valid && (rd_tag == req_tag)) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            DataOut  = rd_data;
          end else begin
            Stall        = 1'b1;
            tag_d        = req_tag;
            idx_d        = req_idx;
            word_d       = req_word;
            issue_cnt_d  = '0;
            ret_cnt_d    = '0;
            issue_done_d = 1'b0;
            state_d      = FILL;
          end
        end
      end
      FILL: begin
        Stall = 1'b1;
        if (!issue_done_q) begin
          mem_rd      = 1'b1;
          mem_addr    = {tag_q, idx_q, issue_cnt_q, 1'b0};
          issue_cnt_d = issue_cnt_q + OFS_W'(1);
          if (issue_cnt_q == LAST_WD) issue_done_d = 1'b1;
        end
        // Returns arrive in issue order, so ret_cnt_q is the word being delivered.
        if (mem_rvalid) begin
          wr_en     = 1'b1;
          ret_cnt_d = ret_cnt_q + OFS_W'(1);
          if (ret_cnt_q == LAST_WD) begin
            set_valid = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        rd_idx  = idx_q;
        rd_word = word_q;
        Done    = 1'b1;
        DataOut = rd_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      issue_cnt_q  <= '0;
      ret_cnt_q    <= '0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      issue_done_q <= issue_done_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    idx_q  <= idx_d;
    word_q <= word_d;
  end
endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: a timeline-level cache model plus a latency-MEM_LAT
// backing memory, directed scenarios with literal expectations, then random traffic.
module tb_icache_responder;
  import icache_pkg::*;

  localparam int DONE_K = 3 + MEM_LAT + LINE_WDS - 2;

  logic        clk;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_rdata;
  logic        Rd, Wr, createdump, Done, Stall, CacheHit, err, mem_rd, mem_rvalid;

  icache_responder dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
    .CacheHit(CacheHit), .err(err), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } mreq_t;

  mreq_t       mq[$];
  int          n_chk, n_err, cyc;
  bit          mvalid [SETS];
  logic [4:0]  mtag   [SETS];
  bit          mbusy;
  int          c0;
  logic [15:0] mreq;
  logic        obs_done, obs_hit, obs_stall, obs_err, obs_mrd;
  logic [15:0] obs_data;
  int          mrd_cnt;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
    mbusy = 1'b0;
    mq.delete();
  endtask

  task automatic check_cycle();
    logic [15:0] e_do, e_ma;
    logic        e_done, e_st, e_hit, e_err, e_mrd;
    logic [7:0]  ix;
    int          k;
    mreq_t       e;
    e_do = '0; e_ma = '0; e_done = 0; e_st = 0; e_hit = 0; e_err = 0; e_mrd = 0;
    ix = Addr[10:3];
    if (mbusy) begin
      k     = cyc - c0;
      e_st  = (k < DONE_K);
      e_mrd = (k >= 1 && k <= LINE_WDS);
      if (e_mrd) e_ma = {mreq[15:3], 3'b000} + 16'(2 * (k - 1));
      if (k == DONE_K) begin
        e_done = 1'b1;
        e_do   = mem_word(mreq);
        mvalid[mreq[10:3]] = 1'b1;
        mtag[mreq[10:3]]   = mreq[15:11];
        mbusy  = 1'b0;
      end
    end else if (Wr || (Rd && Addr[0])) begin
      e_err = 1'b1;
    end else if (Rd) begin
      if (mvalid[ix] && mtag[ix] == Addr[15:11]) begin
        e_done = 1'b1;
        e_hit  = 1'b1;
        e_do   = mem_word({Addr[15:1], 1'b0});
      end else begin
        e_st  = 1'b1;
        mbusy = 1'b1;
        c0    = cyc;
        mreq  = {Addr[15:1], 1'b0};
      end
    end
    chk("DataOut",  DataOut,          e_do);
    chk("Done",     16'(Done),        16'(e_done));
    chk("Stall",    16'(Stall),       16'(e_st));
    chk("CacheHit", 16'(CacheHit),    16'(e_hit));
    chk("err",      16'(err),         16'(e_err));
    chk("mem_rd",   16'(mem_rd),      16'(e_mrd));
    chk("mem_addr", mem_addr,         e_ma);
    if (mem_rd) begin
      e.due  = cyc + MEM_LAT;
      e.addr = mem_addr;
      mq.push_back(e);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [15:0] a, input logic do_rst);
    @(posedge clk);
    #1;
    cyc++;
    rst        = do_rst;
    Rd         = r;
    Wr         = w;
    Addr       = a;
    DataIn     = 16'($urandom);
    createdump = 1'($urandom);
    mem_rvalid = 1'b0;
    mem_rdata  = 16'($urandom);
    if (mq.size() > 0 && mq[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else if (!mbusy && $urandom_range(3) == 0) begin
      mem_rvalid = 1'b1;
    end
    @(negedge clk);
    if (do_rst) model_reset();
    else check_cycle();
    obs_done  = Done;
    obs_hit   = CacheHit;
    obs_stall = Stall;
    obs_err   = err;
    obs_mrd   = mem_rd;
    obs_data  = DataOut;
    if (mem_rd && !do_rst) mrd_cnt++;
  endtask

  // Issues one read and keeps the request up (or scrambles inputs) until the model says done.
  task automatic run_req(input logic [15:0] a, input bit scramble,
                         output int lat, output logic [15:0] dat, output logic hit);
    int k;
    lat = -1; dat = 'x; hit = 1'bx;
    mrd_cnt = 0;
    step(1'b1, 1'b0, a, 1'b0);
    if (obs_done) begin lat = 0; dat = obs_data; hit = obs_hit; end
    k = 0;
    while (mbusy && k < 30) begin
      k++;
      if (scramble) step(1'($urandom), 1'($urandom), 16'($urandom), 1'b0);
      else          step(1'b1, 1'b0, a, 1'b0);
      if (obs_done && lat < 0) begin lat = k; dat = obs_data; hit = obs_hit; end
    end
  endtask

  int          lat;
  logic [15:0] dat, ra;
  logic        hit;
  logic [4:0]  rt;
  logic [7:0]  rix;
  logic [1:0]  rwd;
  int          sel;

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; mrd_cnt = 0;
    rst = 1'b1; Rd = 0; Wr = 0; Addr = 0; DataIn = 0; createdump = 0;
    mem_rvalid = 0; mem_rdata = 0;
    model_reset();
    step(0, 0, 16'h0000, 1'b1);
    step(0, 0, 16'h0000, 1'b1);
    step(0, 0, 16'h0000, 1'b0);
    chk("reset_stall", 16'(obs_stall), 16'd0);
    chk("reset_done",  16'(obs_done),  16'd0);

    run_req(16'h0040, 1'b0, lat, dat, hit);
    chk("miss_lat",   16'(lat),     16'd7);
    chk("miss_data",  dat,          16'h1A5A);
    chk("miss_hit",   16'(hit),     16'd0);
    chk("miss_mrd",   16'(mrd_cnt), 16'd4);

    run_req(16'h0042, 1'b0, lat, dat, hit);
    chk("hit_lat",  16'(lat),     16'd0);
    chk("hit_data", dat,          16'h185A);
    chk("hit_flag", 16'(hit),     16'd1);
    chk("hit_mrd",  16'(mrd_cnt), 16'd0);

    run_req(16'h0840, 1'b0, lat, dat, hit);
    chk("conf_lat",  16'(lat), 16'd7);
    chk("conf_data", dat,      16'h1A52);
    run_req(16'h0040, 1'b0, lat, dat, hit);
    chk("evict_lat",  16'(lat), 16'd7);
    chk("evict_data", dat,      16'h1A5A);

    step(0, 1, 16'h0100, 1'b0);
    chk("wr_err",   16'(obs_err),  16'd1);
    chk("wr_done",  16'(obs_done), 16'd0);
    run_req(16'h0100, 1'b0, lat, dat, hit);
    chk("wr_nofill_lat", 16'(lat), 16'd7);

    step(1, 0, 16'h0041, 1'b0);
    chk("mis_err",   16'(obs_err),   16'd1);
    chk("mis_stall", 16'(obs_stall), 16'd0);
    step(0, 0, 16'h0000, 1'b0);
    chk("mis_norefill", 16'(obs_stall), 16'd0);

    run_req(16'h0200, 1'b1, lat, dat, hit);
    chk("scr_lat",  16'(lat), 16'd7);
    chk("scr_data", dat,      16'h5A58);

    step(1, 0, 16'h0300, 1'b0);
    step(1, 0, 16'h0300, 1'b0);
    step(1, 0, 16'h0300, 1'b0);
    step(1, 0, 16'h0300, 1'b1);
    step(0, 0, 16'h0000, 1'b0);
    chk("rst_stall", 16'(obs_stall), 16'd0);
    chk("rst_mrd",   16'(obs_mrd),   16'd0);
    chk("rst_done",  16'(obs_done),  16'd0);
    run_req(16'h0300, 1'b0, lat, dat, hit);
    chk("rst_refill_lat", 16'(lat),     16'd7);
    chk("rst_refill_mrd", 16'(mrd_cnt), 16'd4);

    for (int n = 0; n < 400; n++) begin
      rt  = 5'($urandom_range(3));
      rix = 8'($urandom_range(3));
      rwd = 2'($urandom_range(3));
      ra  = {rt, rix, rwd, 1'b0};
      sel = $urandom_range(9);
      if (n % 97 == 96)   step(0, 0, ra, 1'b1);
      else if (sel == 0)  step(0, 0, ra, 1'b0);
      else if (sel == 1)  step(1'($urandom), 1'b1, ra, 1'b0);
      else if (sel == 2)  step(1, 0, ra | 16'h0001, 1'b0);
      else                run_req(ra, 1'($urandom), lat, dat, hit);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
